mult_requester: RTL and testbench
=================================

MULT_REQUESTER -- requirements
Module: mult_requester

Interface
REQ-001 Parameter: OPW, default 8, operand width in bits.
REQ-002 Parameter: TIMEOUT, default 15, maximum cycles spent in DRAIN or RUN before an error is declared.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req_valid  input  1  operand request valid.
REQ-006 req_ready  output  1  request accepted when req_valid and req_ready are both 1.
REQ-007 req_a, req_b  input  OPW each  multiplicand and multiplier.
REQ-008 op_a, op_b  output  OPW each  registered operands held to the engine datapath.
REQ-009 start  output  1  engine start request.
REQ-010 count  output  3  step count driven to the engine controller.
REQ-011 locked  input  1  engine busy indication (1 = engine not idle).
REQ-012 done_flag  input  1  engine finished; product valid.
REQ-013 prod  input  2*OPW  engine product.
REQ-014 rsp_valid  output  1  response valid.
REQ-015 rsp_ready  input  1  response accepted when rsp_valid and rsp_ready are both 1.
REQ-016 rsp_data  output  2*OPW  captured product.
REQ-017 rsp_err  output  1  response is an error (timeout).
REQ-018 err_cnt  output  8  saturating count of error responses.

Function
REQ-019 FSM states SHALL be IDLE, DRAIN, ARM, RUN and RESP, encoded in one state register.
- IDLE: req_ready=1; all other control outputs 0.
- On req_valid&req_ready: capture req_a/req_b into op_a/op_b; go to DRAIN.
REQ-020 DRAIN: wait for the engine to be free.
- locked=0 -> ARM.
- locked=1 for TIMEOUT consecutive cycles -> RESP with error.
REQ-021 ARM lasts exactly one cycle with start=1 and count=0, then goes to RUN.
REQ-022 RUN: start=0; count increments by 1 each cycle starting from 1, saturates at 5, and never wraps.
REQ-023 RUN: done_flag=1 sampled -> capture prod into rsp_data, set rsp_err=0, go to RESP on the next edge.
REQ-024 RUN: no done_flag within TIMEOUT cycles of RUN entry -> rsp_data=0, rsp_err=1, go to RESP.
REQ-025 With a nominal engine, done_flag SHALL be observed in the 5th RUN cycle (count=5).
- Latency from request handshake to rsp_valid SHALL be 8 cycles when locked=0 at acceptance.
REQ-026 RESP: rsp_valid=1; rsp_data and rsp_err held stable until rsp_valid&rsp_ready, then IDLE.
- rsp_ready=1 on the first RESP cycle SHALL complete the handshake in that cycle.
REQ-027 req_ready SHALL be 0 in every state except IDLE; only one request is in flight at a time.
REQ-028 op_a/op_b SHALL change only on request acceptance.
REQ-029 Error responses: err_cnt increments by 1 on each error response handshake and saturates at 255.
REQ-030 count and start SHALL be 0 in every state except ARM and RUN.
REQ-031 done_flag and locked SHALL be ignored outside DRAIN and RUN.
- Each done_flag pulse in RUN is consumed exactly once.

Reset
REQ-032 rst=1 at a clock edge, in any state, SHALL force:
- state=IDLE, req_ready=1 on the next cycle;
- start=0, count=0, rsp_valid=0, rsp_err=0;
- rsp_data=0, op_a=0, op_b=0, err_cnt=0.
REQ-033 Reset mid-RUN or mid-RESP SHALL discard the in-flight request without a response.
- The first post-reset request SHALL be accepted normally.

Verification
REQ-034 Nominal: req_a=8'h0D, req_b=8'h0B, locked=0, model engine, rsp_ready=1 -> rsp_data=16'h008F, rsp_err=0, rsp_valid 8 cycles after accept.
REQ-035 Busy engine: locked=1 for 3 cycles after accept -> start asserted on the 5th cycle after accept; correct product returned.
REQ-036 Timeout: done_flag held 0 -> after 15 RUN cycles rsp_valid=1, rsp_err=1, rsp_data=0; err_cnt increments 0->1 at handshake.
REQ-037 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid/rsp_data stable and req_ready=0 throughout; new request accepted the cycle after handshake.
REQ-038 Reset mid-RUN at count=3 -> next cycle all outputs at reset values; a following request 8'hFF x 8'hFF returns 16'hFE01.
REQ-039 Saturation: 260 forced timeouts -> err_cnt=255 and holds.

Source files
------------

// File: rtl/mult_requester.sv
`default_nettype none
// ============================================================================
//  Module      : mult_requester
//  Description : Single-outstanding request front end for a sequential
//                multiplier engine. Accepts one operand pair, waits for the
//                engine to go idle, pulses start for one cycle, steps the
//                engine's count while it runs, and returns the product (or a
//                timeout error) on a valid/ready response channel.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    OPW       operand width in bits
//    TIMEOUT   max cycles allowed in DRAIN or RUN before an error response
//  Ports
//    clk, rst                    clock, synchronous active-high reset
//    req_valid/req_ready         request handshake
//    req_a, req_b                operands (OPW bits each)
//    op_a, op_b                  operands held for the engine datapath
//    start                       one-cycle engine start request
//    count                       step count to the engine controller
//    locked                      engine busy (1 = not idle)
//    done_flag, prod             engine completion and product
//    rsp_valid/rsp_ready         response handshake
//    rsp_data, rsp_err           captured product / timeout error flag
//    err_cnt                     saturating count of error responses
// ============================================================================
module mult_requester #(
    parameter int OPW     = 8,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    // request channel
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [OPW-1:0]     req_a,
    input  logic [OPW-1:0]     req_b,
    // engine interface
    output logic [OPW-1:0]     op_a,
    output logic [OPW-1:0]     op_b,
    output logic               start,
    output logic [2:0]         count,
    input  logic               locked,
    input  logic               done_flag,
    input  logic [2*OPW-1:0]   prod,
    // response channel
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*OPW-1:0]   rsp_data,
    output logic               rsp_err,
    output logic [7:0]         err_cnt
);

    // Timer must be able to hold the value TIMEOUT itself.
    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO       = TW'(TIMEOUT);
    localparam logic [2:0]    COUNT_MAX = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAIN = 3'd1,
        ARM   = 3'd2,
        RUN   = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t        state;
    // Cycles spent in the current DRAIN or RUN phase; 1 on the first cycle.
    logic [TW-1:0] timer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            req_ready <= 1'b1;
            op_a      <= '0;
            op_b      <= '0;
            start     <= 1'b0;
            count     <= 3'd0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_a      <= req_a;
                        op_b      <= req_b;
                        req_ready <= 1'b0;
                        timer     <= TW'(1);
                        state     <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (!locked) begin
                        start <= 1'b1;
                        count <= 3'd0;
                        state <= ARM;
                    end else if (timer == TMO) begin
                        // Engine never freed up: answer with an error.
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                ARM: begin
                    // start is high for exactly this one cycle.
                    start <= 1'b0;
                    count <= 3'd1;
                    timer <= TW'(1);
                    state <= RUN;
                end

                RUN: begin
                    if (done_flag) begin
                        rsp_data  <= prod;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        count     <= 3'd0;
                        state     <= RESP;
                    end else if (timer == TMO) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        count     <= 3'd0;
                        state     <= RESP;
                    end else begin
                        timer <= timer + TW'(1);
                        // Step count saturates rather than wrapping.
                        if (count != COUNT_MAX) begin
                            count <= count + 3'd1;
                        end
                    end
                end

                RESP: begin
                    // rsp_data / rsp_err are left untouched here so they
                    // stay stable for as long as the consumer stalls.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                        if (rsp_err && (err_cnt != 8'hFF)) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    start     <= 1'b0;
                    count     <= 3'd0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_requester
//  Description : Directed self-checking bench for mult_requester with a
//                simple engine model (done_flag when count reaches 5).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_a, req_b;
    logic [7:0]  op_a, op_b;
    logic        start;
    logic [2:0]  count;
    logic        locked;
    logic        done_flag;
    logic [15:0] prod;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [7:0]  err_cnt;

    // Engine model: completes when the step count reaches 5.
    logic        eng_en;
    assign done_flag = eng_en && (count == 3'd5);
    assign prod      = {8'd0, op_a} * {8'd0, op_b};

    int n_vec = 0;
    int n_err = 0;

    mult_requester #(.OPW(8), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .op_a      (op_a),
        .op_b      (op_b),
        .start     (start),
        .count     (count),
        .locked    (locked),
        .done_flag (done_flag),
        .prod      (prod),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and return at the first cycle with rsp_valid high.
    // Indices are cycles after acceptance: the cycle right after the
    // accepting edge is index 1.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                           input int lock_cycles,
                           output int start_idx, output int rsp_idx);
        int n;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        start_idx = -1;
        rsp_idx   = -1;
        n         = 0;
        while (n < 60) begin
            if (start && start_idx < 0) start_idx = n + 1;
            if (rsp_valid) begin
                rsp_idx = n + 1;
                break;
            end
            locked = (n < lock_cycles);
            tick();
            n++;
        end
        locked = 1'b0;
        if (rsp_idx < 0) chk("rsp_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({pfx, "_start"},     32'(start),     32'd0);
        chk({pfx, "_count"},     32'(count),     32'd0);
        chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({pfx, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({pfx, "_rsp_data"},  32'(rsp_data),  32'd0);
        chk({pfx, "_op_a"},      32'(op_a),      32'd0);
        chk({pfx, "_op_b"},      32'(op_b),      32'd0);
        chk({pfx, "_err_cnt"},   32'(err_cnt),   32'd0);
    endtask

    initial begin
        int s_idx, r_idx, n;
        logic stable_ok;

        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
        locked = 1'b0; rsp_ready = 1'b1; eng_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk_reset_vals("reset");

        // Nominal: 0x0D * 0x0B = 0x8F, start in cycle 2, response in cycle 8.
        run_txn(8'h0D, 8'h0B, 0, s_idx, r_idx);
        chk("nom_op_a",      32'(op_a),     32'h0D);
        chk("nom_op_b",      32'(op_b),     32'h0B);
        chk("nom_start_idx", 32'(s_idx),    32'd2);
        chk("nom_rsp_idx",   32'(r_idx),    32'd8);
        chk("nom_rsp_data",  32'(rsp_data), 32'h008F);
        chk("nom_rsp_err",   32'(rsp_err),  32'd0);
        chk("nom_req_ready", 32'(req_ready),32'd0);
        chk("nom_count",     32'(count),    32'd0);
        tick();
        chk("nom_hs_valid",  32'(rsp_valid),32'd0);
        chk("nom_hs_ready",  32'(req_ready),32'd1);
        chk("nom_err_cnt",   32'(err_cnt),  32'd0);

        // Busy engine for 3 cycles: 0x12 * 0x34 = 0x03A8, start in cycle 5.
        run_txn(8'h12, 8'h34, 3, s_idx, r_idx);
        chk("busy_start_idx", 32'(s_idx),    32'd5);
        chk("busy_rsp_idx",   32'(r_idx),    32'd11);
        chk("busy_rsp_data",  32'(rsp_data), 32'h03A8);
        chk("busy_rsp_err",   32'(rsp_err),  32'd0);
        tick();

        // RUN timeout: engine never finishes; 15 RUN cycles (3..17) then RESP.
        eng_en = 1'b0;
        rsp_ready = 1'b0;
        run_txn(8'h21, 8'h43, 0, s_idx, r_idx);
        chk("tmo_rsp_idx",   32'(r_idx),    32'd18);
        chk("tmo_rsp_err",   32'(rsp_err),  32'd1);
        chk("tmo_rsp_data",  32'(rsp_data), 32'h0000);
        chk("tmo_err_cnt0",  32'(err_cnt),  32'd0);
        rsp_ready = 1'b1;
        tick();
        chk("tmo_err_cnt1",  32'(err_cnt),  32'd1);
        chk("tmo_hs_valid",  32'(rsp_valid),32'd0);
        eng_en = 1'b1;

        // Backpressure: 0x07 * 0x06 = 0x2A held for 10 stalled cycles.
        rsp_ready = 1'b0;
        run_txn(8'h07, 8'h06, 0, s_idx, r_idx);
        stable_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h002A || req_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        chk("bp_stable", 32'(stable_ok), 32'd1);
        // Offer the next request while handshaking; it lands one cycle later.
        rsp_ready = 1'b1;
        req_a = 8'h03; req_b = 8'h05; req_valid = 1'b1;
        tick();
        chk("bp_hs_valid",  32'(rsp_valid), 32'd0);
        chk("bp_hs_ready",  32'(req_ready), 32'd1);
        chk("bp_hs_op_a",   32'(op_a),      32'h07);
        tick();
        req_valid = 1'b0;
        chk("bp_next_op_a", 32'(op_a),      32'h03);
        chk("bp_next_ready",32'(req_ready), 32'd0);
        n = 0;
        while (!rsp_valid && n < 40) begin tick(); n++; end
        chk("bp_next_data", 32'(rsp_data),  32'h000F);
        tick();

        // Reset during RUN at count 3, then FF * FF = FE01.
        req_a = 8'h11; req_b = 8'h22; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (count != 3'd3 && n < 20) begin tick(); n++; end
        chk("rstrun_reached_3", 32'(count), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rstrun");
        tick();
        chk("rstrun_no_rsp", 32'(rsp_valid), 32'd0);
        run_txn(8'hFF, 8'hFF, 0, s_idx, r_idx);
        chk("rstrun_rsp_idx",  32'(r_idx),    32'd8);
        chk("rstrun_rsp_data", 32'(rsp_data), 32'hFE01);
        tick();

        // DRAIN timeout latency, then saturate err_cnt with 260 errors.
        run_txn(8'h01, 8'h01, 999, s_idx, r_idx);
        chk("drain_tmo_idx",   32'(r_idx),   32'd16);
        chk("drain_tmo_start", 32'(s_idx),   32'hFFFF_FFFF);
        chk("drain_tmo_err",   32'(rsp_err), 32'd1);
        tick();
        chk("drain_err_cnt",   32'(err_cnt), 32'd1);
        for (int i = 0; i < 259; i++) begin
            run_txn(8'h02, 8'h02, 999, s_idx, r_idx);
            tick();
        end
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);
        run_txn(8'h02, 8'h02, 999, s_idx, r_idx);
        tick();
        chk("sat_hold",    32'(err_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
